// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake states, data word, memory arbiter FSM states
// and default access timeout.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    IBUSY = 2'b01,
    DBUSY = 2'b10,
    FAULT = 2'b11
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  localparam int unsigned MEM_ARB_TIMEOUT = 16;

endpackage

// File: rtl/mem_arb_timer.sv
// Outstanding-access cycle counter for mem_arbiter; expired flags that the
// count has reached TIMEOUT-1.
module mem_arb_timer
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = MEM_ARB_TIMEOUT
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Instruction/data memory arbiter in front of a single RAM port.
// Optional MEM_ARB_RR_EN: round-robin tie-break instead of fixed data priority.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = MEM_ARB_TIMEOUT
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      iwait,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dwait,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      memerr
);

  arb_state_t state, next_state;
  logic       d_req;
  logic       busy;
  logic       expired;

  assign d_req = dREN | dWEN;
  assign busy  = (state == IBUSY) || (state == DBUSY);

  assign iload = ramload;
  assign dload = ramload;

  mem_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .CLK    (CLK),
    .nRST   (nRST),
    .clear  (state == IDLE),
    .enable (busy && (ramstate != ACCESS)),
    .expired(expired)
  );

`ifdef MEM_ARB_RR_EN
  grant_t last_grant;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      last_grant <= GRANT_I;
    end else if (state == IDLE && next_state == IBUSY) begin
      last_grant <= GRANT_I;
    end else if (state == IDLE && next_state == DBUSY) begin
      last_grant <= GRANT_D;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state  <= IDLE;
      memerr <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == FAULT) begin
        memerr <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;

    unique case (state)
      IDLE: begin
`ifdef MEM_ARB_RR_EN
        if (d_req && iREN) begin
          next_state = (last_grant == GRANT_I) ? DBUSY : IBUSY;
        end else if (d_req) begin
          next_state = DBUSY;
        end else if (iREN) begin
          next_state = IBUSY;
        end
`else
        if (d_req) begin
          next_state = DBUSY;
        end else if (iREN) begin
          next_state = IBUSY;
        end
`endif
      end

      IBUSY: begin
        iwait = (ramstate != ACCESS);
        // A dropped request aborts: RAM lines stay at 0 and we fall back to IDLE.
        if (!iREN) begin
          next_state = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == ERROR)       next_state = FAULT;
          else if (ramstate == ACCESS) next_state = IDLE;
          else if (expired)            next_state = FAULT;
        end
      end

      DBUSY: begin
        dwait = (ramstate != ACCESS);
        if (!d_req) begin
          next_state = IDLE;
        end else begin
          ramREN   = dREN & ~dWEN;
          ramWEN   = dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ramstate == ERROR)       next_state = FAULT;
          else if (ramstate == ACCESS) next_state = IDLE;
          else if (expired)            next_state = FAULT;
        end
      end

      FAULT: begin
        next_state = FAULT;
      end

      default: begin
        next_state = IDLE;
      end
    endcase

    // Synchronous reset still quiets the RAM port during the reset cycle itself.
    if (!nRST) begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cycle vector table plus directed
// timeout, ERROR, mid-access reset and tie-break sequences.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;
  word_t     iload, dload, ramaddr, ramstore;
  logic      iwait, dwait, ramREN, ramWEN, memerr;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(
    .TIMEOUT(4)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iload   (iload),
    .iwait   (iwait),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dload   (dload),
    .dwait   (dwait),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate),
    .memerr  (memerr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic      nrst, iren, dren, dwen;
    word_t     ia, da, ds, rl;
    ramstate_t rs;
    logic      e_ren, e_wen;
    word_t     e_addr, e_store;
    logic      e_iwait, e_dwait, e_err;
  } vec_t;

  function automatic vec_t mk(logic nrst, logic iren, logic dren, logic dwen,
                              word_t ia, word_t da, word_t ds, word_t rl,
                              ramstate_t rs, logic e_ren, logic e_wen,
                              word_t e_addr, word_t e_store,
                              logic e_iwait, logic e_dwait, logic e_err);
    vec_t v;
    v.nrst = nrst; v.iren = iren; v.dren = dren; v.dwen = dwen;
    v.ia = ia; v.da = da; v.ds = ds; v.rl = rl; v.rs = rs;
    v.e_ren = e_ren; v.e_wen = e_wen; v.e_addr = e_addr; v.e_store = e_store;
    v.e_iwait = e_iwait; v.e_dwait = e_dwait; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then settle before checks.
  task automatic drive(input logic nrst, input logic iren, input logic dren,
                       input logic dwen, input word_t ia, input word_t da,
                       input word_t ds, input word_t rl, input ramstate_t rs);
    @(negedge CLK);
    nRST = nrst; iREN = iren; dREN = dren; dWEN = dwen;
    iaddr = ia; daddr = da; dstore = ds; ramload = rl; ramstate = rs;
    #1;
  endtask

  vec_t vecs[17];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    repeat (2) @(posedge CLK);

    //           nrst i d w  iaddr  daddr  dstore        ramload       rs      ren wen addr   store         iw dw err
    vecs[0]  = mk(0, 1,0,0, 32'h40, 32'h0,   32'h0,        32'h0,        FREE,   0,0, 32'h0,   32'h0,        1,1,0);
    vecs[1]  = mk(1, 1,0,0, 32'h40, 32'h0,   32'h0,        32'h0,        FREE,   0,0, 32'h0,   32'h0,        1,1,0);
    vecs[2]  = mk(1, 1,0,0, 32'h40, 32'h0,   32'h0,        32'h0,        BUSY,   1,0, 32'h40,  32'h0,        1,1,0);
    vecs[3]  = mk(1, 1,0,0, 32'h40, 32'h0,   32'h0,        32'h0,        BUSY,   1,0, 32'h40,  32'h0,        1,1,0);
    vecs[4]  = mk(1, 1,0,0, 32'h40, 32'h0,   32'h0,        32'h2402000A, ACCESS, 1,0, 32'h40,  32'h0,        0,1,0);
    vecs[5]  = mk(1, 1,0,0, 32'h40, 32'h0,   32'h0,        32'h2402000A, ACCESS, 0,0, 32'h0,   32'h0,        1,1,0);
    vecs[6]  = mk(1, 0,0,0, 32'h40, 32'h0,   32'h0,        32'h0,        FREE,   0,0, 32'h0,   32'h0,        1,1,0);
    vecs[7]  = mk(1, 1,0,1, 32'h80, 32'h100, 32'hDEADBEEF, 32'h0,        FREE,   0,0, 32'h0,   32'h0,        1,1,0);
    vecs[8]  = mk(1, 1,0,1, 32'h80, 32'h100, 32'hDEADBEEF, 32'h0,        ACCESS, 0,1, 32'h100, 32'hDEADBEEF, 1,0,0);
    vecs[9]  = mk(1, 1,0,0, 32'h80, 32'h100, 32'hDEADBEEF, 32'h0,        FREE,   0,0, 32'h0,   32'h0,        1,1,0);
    vecs[10] = mk(1, 1,0,0, 32'h80, 32'h100, 32'hDEADBEEF, 32'h11111111, ACCESS, 1,0, 32'h80,  32'h0,        0,1,0);
    vecs[11] = mk(1, 0,1,0, 32'h80, 32'h200, 32'h55,       32'h0,        FREE,   0,0, 32'h0,   32'h0,        1,1,0);
    vecs[12] = mk(1, 0,1,0, 32'h80, 32'h200, 32'h55,       32'h0,        BUSY,   1,0, 32'h200, 32'h55,       1,1,0);
    vecs[13] = mk(1, 0,0,0, 32'h80, 32'h200, 32'h55,       32'h0,        BUSY,   0,0, 32'h0,   32'h0,        1,1,0);
    vecs[14] = mk(1, 0,1,1, 32'h0,  32'h300, 32'hCAFEF00D, 32'h0,        FREE,   0,0, 32'h0,   32'h0,        1,1,0);
    vecs[15] = mk(1, 0,1,1, 32'h0,  32'h300, 32'hCAFEF00D, 32'h0,        ACCESS, 0,1, 32'h300, 32'hCAFEF00D, 1,0,0);
    vecs[16] = mk(1, 0,0,0, 32'h0,  32'h0,   32'h0,        32'h0,        FREE,   0,0, 32'h0,   32'h0,        1,1,0);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].nrst, vecs[i].iren, vecs[i].dren, vecs[i].dwen,
            vecs[i].ia, vecs[i].da, vecs[i].ds, vecs[i].rl, vecs[i].rs);
      chk($sformatf("vec%0d.ramREN", i),   {31'b0, ramREN}, {31'b0, vecs[i].e_ren});
      chk($sformatf("vec%0d.ramWEN", i),   {31'b0, ramWEN}, {31'b0, vecs[i].e_wen});
      chk($sformatf("vec%0d.ramaddr", i),  ramaddr,         vecs[i].e_addr);
      chk($sformatf("vec%0d.ramstore", i), ramstore,        vecs[i].e_store);
      chk($sformatf("vec%0d.iwait", i),    {31'b0, iwait},  {31'b0, vecs[i].e_iwait});
      chk($sformatf("vec%0d.dwait", i),    {31'b0, dwait},  {31'b0, vecs[i].e_dwait});
      chk($sformatf("vec%0d.memerr", i),   {31'b0, memerr}, {31'b0, vecs[i].e_err});
      chk($sformatf("vec%0d.iload", i),    iload,           vecs[i].rl);
      chk($sformatf("vec%0d.dload", i),    dload,           vecs[i].rl);
    end

    // Timeout with TIMEOUT=4: four BUSY cycles, then sticky FAULT.
    drive(1, 1, 0, 0, 32'h40, 32'h0, 32'h0, 32'h0, BUSY);
    chk("to.idle.ramREN", {31'b0, ramREN}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      drive(1, 1, 0, 0, 32'h40, 32'h0, 32'h0, 32'h0, BUSY);
      chk($sformatf("to.busy%0d.ramREN", k), {31'b0, ramREN}, 32'd1);
      chk($sformatf("to.busy%0d.memerr", k), {31'b0, memerr}, 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 1, 0, 32'h40, 32'h44, 32'h0, 32'h0, ACCESS);
      chk($sformatf("to.fault%0d.memerr", k), {31'b0, memerr}, 32'd1);
      chk($sformatf("to.fault%0d.ramREN", k), {31'b0, ramREN}, 32'd0);
      chk($sformatf("to.fault%0d.iwait", k),  {31'b0, iwait},  32'd1);
      chk($sformatf("to.fault%0d.dwait", k),  {31'b0, dwait},  32'd1);
      chk($sformatf("to.fault%0d.ramaddr", k), ramaddr, 32'h0);
    end
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, FREE);
    chk("to.rst.memerr_before_edge", {31'b0, memerr}, 32'd1);
    drive(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, FREE);
    chk("to.after_rst.memerr", {31'b0, memerr}, 32'd0);

    // ERROR during IBUSY enters FAULT on the next cycle.
    drive(1, 1, 0, 0, 32'h40, 32'h0, 32'h0, 32'h0, FREE);
    drive(1, 1, 0, 0, 32'h40, 32'h0, 32'h0, 32'h0, ERROR);
    chk("err.ibusy.ramREN", {31'b0, ramREN}, 32'd1);
    chk("err.ibusy.memerr", {31'b0, memerr}, 32'd0);
    drive(1, 1, 0, 0, 32'h40, 32'h0, 32'h0, 32'h0, FREE);
    chk("err.fault.memerr", {31'b0, memerr}, 32'd1);
    chk("err.fault.ramREN", {31'b0, ramREN}, 32'd0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, FREE);
    drive(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, FREE);
    chk("err.after_rst.memerr", {31'b0, memerr}, 32'd0);

    // Reset asserted in the middle of a data access.
    drive(1, 0, 1, 0, 32'h0, 32'h44, 32'h0, 32'h0, FREE);
    drive(1, 0, 1, 0, 32'h0, 32'h44, 32'h0, 32'h0, BUSY);
    chk("mrst.dbusy.ramaddr", ramaddr, 32'h44);
    drive(0, 0, 1, 0, 32'h0, 32'h44, 32'h0, 32'h0, BUSY);
    chk("mrst.during.ramREN",  {31'b0, ramREN}, 32'd0);
    chk("mrst.during.ramaddr", ramaddr, 32'h0);
    chk("mrst.during.dwait",   {31'b0, dwait},  32'd1);
    drive(1, 0, 1, 0, 32'h0, 32'h44, 32'h0, 32'h0, BUSY);
    chk("mrst.after.ramREN",  {31'b0, ramREN}, 32'd0);
    chk("mrst.after.ramaddr", ramaddr, 32'h0);
    drive(1, 0, 1, 0, 32'h0, 32'h44, 32'h0, 32'h0, BUSY);
    chk("mrst.regrant.ramREN", {31'b0, ramREN}, 32'd1);
    drive(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, FREE);

    // Tie after a data grant: round-robin favours instruction, fixed priority data.
    drive(1, 0, 1, 0, 32'h600, 32'h500, 32'h0, 32'h0, FREE);
    drive(1, 0, 1, 0, 32'h600, 32'h500, 32'h0, 32'h0, ACCESS);
    chk("tie.pre.dwait", {31'b0, dwait}, 32'd0);
    drive(1, 1, 1, 0, 32'h600, 32'h500, 32'h0, 32'h0, FREE);
    chk("tie.idle.ramREN", {31'b0, ramREN}, 32'd0);
    drive(1, 1, 1, 0, 32'h600, 32'h500, 32'h0, 32'h0, BUSY);
    chk("tie.grant.ramREN", {31'b0, ramREN}, 32'd1);
`ifdef MEM_ARB_RR_EN
    chk("tie.grant.ramaddr", ramaddr, 32'h600);
`else
    chk("tie.grant.ramaddr", ramaddr, 32'h500);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
